regfile_preloader: RTL and testbench

- Hardware writer that fills the register file with initial values before the processor starts executing.
- Sits between the processor's regfile write port and the regfile itself. Holds the processor in reset while a host streams (register, value) pairs in over a valid/ready handshake.
- Once loading ends, it releases the processor for a programmed number of cycles, then freezes it so a reader can inspect the final register state.
- This block writes the register state that the end-of-run register check reads back.

---
 rtl/regfile_preloader.sv | 123 ++++++++++++
 tb/tb_regfile_preloader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_preloader.sv
// Preloads the regfile from a host stream, runs the CPU for a set cycle count, then freezes it.
// Latency: preload and CPU writes reach rf_* combinationally; in_ready is high only in LOAD.
module regfile_preloader #(
  parameter  int CYC_W = 10,
  parameter  int NREG  = 32,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_addr,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  input  logic [CYC_W-1:0]  num_cycles,
  input  logic              cpu_we,
  input  logic [IDX_W-1:0]  cpu_rd,
  input  logic [31:0]       cpu_wdata,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_rd,
  output logic [31:0]       rf_wdata,
  output logic              cpu_hold,
  output logic              running,
  output logic              done,
  output logic [5:0]        load_count,
  output logic              zero_write_err
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] LCNT_MAX = 6'd63;

  state_t           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] limit_q, limit_d;
  logic [5:0]       lcnt_q, lcnt_d;
  logic             zerr_q, zerr_d;
  logic             accept;
  logic             last_run_cyc;

  assign last_run_cyc   = (cnt_q == (limit_q - CYC_W'(1)));
  assign load_count     = lcnt_q;
  assign zero_write_err = zerr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      limit_q <= '0;
      lcnt_q  <= '0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      lcnt_q  <= lcnt_d;
      zerr_q  <= zerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    lcnt_d   = lcnt_q;
    zerr_d   = zerr_q;
    accept   = 1'b0;
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    running  = 1'b0;
    done     = 1'b0;
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;

    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        rf_rd    = in_addr;
        rf_wdata = in_data;
        if (accept) begin
          // r0 is architecturally zero: flag the attempt but never write it
          if (in_addr == '0) begin
            zerr_d = 1'b1;
          end else begin
            rf_we = 1'b1;
            if (lcnt_q != LCNT_MAX) lcnt_d = lcnt_q + 6'd1;
          end
          if (in_last) begin
            limit_d = num_cycles;
            cnt_d   = '0;
            state_d = (num_cycles == '0) ? S_DONE : S_RUN;
          end
        end
      end

      S_RUN: begin
        cpu_hold = 1'b0;
        running  = 1'b1;
        rf_we    = cpu_we;
        rf_rd    = cpu_rd;
        rf_wdata = cpu_wdata;
        cnt_d    = cnt_q + CYC_W'(1);
        // limit is never zero here, so limit-1 cannot underflow and cnt never wraps
        if (last_run_cyc) state_d = S_DONE;
      end

      S_DONE: begin
        done = 1'b1;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_preloader.sv
// Bench for regfile_preloader: table vectors, directed corner sequences and random runs
// checked against a phase/remaining-cycles model with its own copy of the register file.
module tb_regfile_preloader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        in_last;
  logic [9:0]  num_cycles;
  logic        cpu_we;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        cpu_hold;
  logic        running;
  logic        done;
  logic [5:0]  load_count;
  logic        zero_write_err;

  regfile_preloader #(.CYC_W(10), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .in_last(in_last), .num_cycles(num_cycles),
    .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .cpu_hold(cpu_hold), .running(running), .done(done),
    .load_count(load_count), .zero_write_err(zero_write_err)
  );

  always #5 clock = ~clock;

  // The register file this block feeds
  logic [31:0] rf_mem [32] = '{default: 32'd0};
  always @(posedge clock) if (rf_we) rf_mem[rf_rd] <= rf_wdata;

  int total = 0;
  int bad   = 0;

  // Reference model: phase, cycles still to run, beats counted, error flag, expected regfile
  localparam int PH_LOAD = 0, PH_RUN = 1, PH_DONE = 2;
  int          m_ph;
  int          m_left;
  int          m_lc;
  logic        m_err;
  logic [31:0] exp_rf [32] = '{default: 32'd0};

  logic        obs_we, obs_running;
  logic [4:0]  obs_rd;
  logic [31:0] obs_wd;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        last;
    logic [9:0]  nc;
    logic        e_we;
    int          e_lc;
    logic        e_err;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, return after edge
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d, input logic last,
                     input logic [9:0] nc, input logic cwe, input logic [4:0] crd,
                     input logic [31:0] cwd, input logic rst);
    logic        e_rdy, e_hold, e_run, e_done, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    @(negedge clock);
    in_valid = v; in_addr = a; in_data = d; in_last = last; num_cycles = nc;
    cpu_we = cwe; cpu_rd = crd; cpu_wdata = cwd; reset = rst;
    #1;
    e_rdy = 0; e_hold = 1; e_run = 0; e_done = 0; e_we = 0; e_rd = a; e_wd = d;
    if (m_ph == PH_LOAD) begin
      e_rdy = 1;
      e_we  = v && (a != 0);
    end else if (m_ph == PH_RUN) begin
      e_hold = 0; e_run = 1; e_we = cwe; e_rd = crd; e_wd = cwd;
    end else begin
      e_done = 1;
    end
    chk("in_ready", in_ready, e_rdy);
    chk("cpu_hold", cpu_hold, e_hold);
    chk("running", running, e_run);
    chk("done", done, e_done);
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_rd", rf_rd, e_rd);
      chk("rf_wdata", rf_wdata, e_wd);
    end
    chk("load_count", load_count, m_lc);
    chk("zero_write_err", zero_write_err, m_err);
    obs_we = rf_we; obs_running = running; obs_rd = rf_rd; obs_wd = rf_wdata;

    if (e_we) exp_rf[e_rd] = e_wd;
    if (rst) begin
      m_ph = PH_LOAD; m_left = 0; m_lc = 0; m_err = 0;
    end else if (m_ph == PH_LOAD) begin
      if (v) begin
        if (a == 0) m_err = 1;
        else if (m_lc < 63) m_lc++;
        if (last) begin
          m_left = nc;
          m_ph   = (nc == 0) ? PH_DONE : PH_RUN;
        end
      end
    end else if (m_ph == PH_RUN) begin
      m_left--;
      if (m_left == 0) m_ph = PH_DONE;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic readback();
    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf_mem[i], exp_rf[i]);
  endtask

  // Run until done with a bound; returns how many cycles the CPU was released
  task automatic run_to_done(input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      cyc(0, 0, 0, 0, 0, 1'b1, 5'd3, 32'd42 + 32'(i), 0);
      if (obs_running) n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 5'd1,  32'd5,          0, 10'd0, 1, 1, 0};
    tbl[1] = '{1, 5'd2,  32'hFFFF_FFF9,  0, 10'd0, 1, 2, 0};
    tbl[2] = '{0, 5'd7,  32'd123,        0, 10'd0, 0, 2, 0};
    tbl[3] = '{1, 5'd0,  32'd99,         0, 10'd0, 0, 2, 1};
    tbl[4] = '{1, 5'd5,  32'd1,          0, 10'd0, 1, 3, 1};
    tbl[5] = '{1, 5'd5,  32'd2,          0, 10'd0, 1, 4, 1};
    tbl[6] = '{1, 5'd31, 32'h7FFF_FFFF,  1, 10'd4, 1, 5, 1};

    in_valid = 0; in_addr = 0; in_data = 0; in_last = 0; num_cycles = 0;
    cpu_we = 0; cpu_rd = 0; cpu_wdata = 0; reset = 1;
    repeat (2) @(posedge clock);
    #1;
    m_ph = PH_LOAD; m_left = 0; m_lc = 0; m_err = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_zero_err", zero_write_err, 0);
    chk("rst_rf_we", rf_we, 0);

    // Table-driven preload, then a 4-cycle run with CPU writes to r3
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].last, tbl[i].nc, 1'b1, 5'd3, 32'd77, 0);
      chk($sformatf("tbl%0d_we", i), obs_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_lc", i), load_count, tbl[i].e_lc);
      chk($sformatf("tbl%0d_err", i), zero_write_err, tbl[i].e_err);
    end
    chk("run_entered", running, 1);
    cyc(0, 0, 0, 0, 0, 1'b1, 5'd3, 32'd42, 0);
    chk("run_mirror_we", obs_we, 1);
    chk("run_mirror_rd", obs_rd, 3);
    chk("run_mirror_wd", obs_wd, 42);
    run_to_done(20, n);
    chk("run_len4", n + 1, 4);
    cyc(1, 5'd4, 32'd5, 1, 10'd3, 1'b1, 5'd3, 32'd42, 0);
    chk("done_blocks_we", obs_we, 0);
    chk("done_hold", cpu_hold, 1);
    chk("rb_r1", rf_mem[1], 32'd5);
    chk("rb_r2", rf_mem[2], 32'hFFFF_FFF9);
    chk("rb_r5", rf_mem[5], 32'd2);
    chk("rb_r31", rf_mem[31], 32'd2147483647);
    readback();

    // Idle LOAD with CPU activity, r0 beat, then reset while the run counter is at 2
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 5'd6, 32'd9, 0, 10'd0, 1'b1, 5'd3, 32'd42, 0);
      chk("idle_no_we", obs_we, 0);
    end
    chk("idle_still_load", in_ready, 1);
    cyc(1, 5'd0, 32'd99, 0, 10'd0, 0, 0, 0, 0);
    cyc(1, 5'd4, 32'd1, 1, 10'd5, 0, 0, 0, 0);
    chk("r0_err", zero_write_err, 1);
    chk("r0_lc", load_count, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_lc", load_count, 0);
    chk("mid_rst_err", zero_write_err, 0);

    // Zero-length run goes straight to DONE
    cyc(1, 5'd9, 32'd77, 1, 10'd0, 0, 0, 0, 0);
    chk("nc0_done", done, 1);
    chk("nc0_hold", cpu_hold, 1);
    readback();

    // load_count saturation, then the longest run length
    do_reset();
    for (int i = 0; i < 70; i++) cyc(1, 5'(1 + i % 31), 32'(i), 0, 10'd0, 0, 0, 0, 0);
    chk("lc_sat", load_count, 63);
    cyc(1, 5'd8, 32'd8, 1, 10'd1023, 0, 0, 0, 0);
    run_to_done(1100, n);
    chk("run_len1023", n, 1023);
    readback();

    // Random sessions
    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int k = 0; k < 150 && m_ph != PH_DONE; k++)
        cyc($urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom_range(0, 9) == 0,
            10'($urandom_range(0, 15)), 1'($urandom), 5'($urandom), $urandom,
            $urandom_range(0, 199) == 0);
      for (int k = 0; k < 3; k++)
        cyc(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 10'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom), $urandom, 0);
      readback();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
